// File: rtl/rr_mux_arbiter_if.sv
// Bus between the requesters and the round-robin mux arbiter: requests, data
// bits and enable in, registered select/grant/busy and mux output back.
interface rr_mux_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] din;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       y;

    modport master (output en, req, din, input sel, gnt, busy, y);
    modport slave  (input en, req, din, output sel, gnt, busy, y);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing an 8:1 single-bit mux between 8 requesters,
// with tenure bounded to MAX_HOLD cycles and a registered mux output.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HCW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux_arbiter_if.slave    bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_reg, state_next;
    logic [2:0]     ptr_reg, ptr_next;
    logic [2:0]     sel_reg, sel_next;
    logic [7:0]     gnt_reg, gnt_next;
    logic           busy_reg, busy_next;
    logic           y_reg, y_next;
    logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;

    logic [7:0]     masked_req;
    logic [7:0]     search_vec;
    logic [7:0]     rot_vec;
    logic [2:0]     search_start;
    logic [2:0]     win_off;
    logic [2:0]     win_idx;
    logic           win_found;
    logic           release_grant;

    // The current holder is masked out so a release always hands over to someone else.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign masked_req[gi] = bus.req[gi] & (sel_reg != 3'(gi));
        end
    endgenerate

    always_comb begin
        search_vec   = bus.req;
        search_start = ptr_reg;
        if (state_reg == GRANT) begin
            search_vec   = masked_req;
            search_start = sel_reg + 3'd1;
        end
    end

    // Rotate so that bit 0 of rot_vec is the highest-priority index.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            logic [2:0] idx;
            assign idx         = search_start + 3'(gi);
            assign rot_vec[gi] = search_vec[idx];
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_vec[i]) begin
                win_off = 3'(i);
            end
        end
    end

    assign win_found     = |rot_vec;
    assign win_idx       = search_start + win_off;
    assign release_grant = !bus.req[sel_reg] || (hold_cnt_reg == HCW'(MAX_HOLD)) || !bus.en;

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        sel_next      = sel_reg;
        gnt_next      = gnt_reg;
        busy_next     = busy_reg;
        hold_cnt_next = hold_cnt_reg;
        y_next        = (state_reg == GRANT) ? bus.din[sel_reg] : 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.en && win_found) begin
                    state_next    = GRANT;
                    sel_next      = win_idx;
                    gnt_next      = 8'd1 << win_idx;
                    busy_next     = 1'b1;
                    hold_cnt_next = HCW'(1);
                end
            end
            GRANT: begin
                if (!release_grant) begin
                    hold_cnt_next = hold_cnt_reg + HCW'(1);
                end else begin
                    ptr_next = sel_reg + 3'd1;
                    if (bus.en && win_found) begin
                        sel_next      = win_idx;
                        gnt_next      = 8'd1 << win_idx;
                        busy_next     = 1'b1;
                        hold_cnt_next = HCW'(1);
                    end else begin
                        state_next    = IDLE;
                        gnt_next      = 8'd0;
                        busy_next     = 1'b0;
                        hold_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 3'd0;
            sel_reg      <= 3'd0;
            gnt_reg      <= 8'd0;
            busy_reg     <= 1'b0;
            y_reg        <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            sel_reg      <= sel_next;
            gnt_reg      <= gnt_next;
            busy_reg     <= busy_next;
            y_reg        <= y_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign bus.sel  = sel_reg;
    assign bus.gnt  = gnt_reg;
    assign bus.busy = busy_reg;
    assign bus.y    = y_reg;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8:1 single-bit mux datapath.
- Shares the mux between 8 requesters.
- Drives the 3-bit select and a one-hot grant, and registers the selected data bit.
- Bounds each tenure to MAX_HOLD cycles so no requester can starve the others.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester may hold the grant; legal range 1..15.
- HCW, 4: hold counter width; must satisfy 2^HCW > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- en  input  1  arbitration enable; low forces release and blocks new grants.
- req  input  8  request vector; req[k] from requester k; level-sensitive.
- din  input  8  mux data inputs; din[k] is requester k's data bit (i0..i7).
- sel  output  3  registered mux select; index of the current grant holder.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- busy  output  1  registered; high while any grant is active.
- y  output  1  registered mux output; din[sel] delayed one cycle, 0 when not granted.

Behaviour:
- Reset (rst=1 at an edge): sel=0, gnt=0, busy=0, y=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides all other inputs. A reset during a grant drops it on that edge.
- ptr (3-bit) is the highest-priority index.
- Search order is ptr, ptr+1, ..., ptr+7, mod 8; the first set bit wins.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0 at edge t, the winner k is chosen with ptr.
  - At t+1: state=GRANT, sel=k, gnt=1<<k, busy=1, hold_cnt=1. Request-to-grant latency is one cycle.
  - Otherwise remain IDLE with outputs held at their idle values.
- GRANT, release condition (evaluated at each edge): req[sel]=0, OR hold_cnt==MAX_HOLD, OR en=0.
- GRANT, no release: hold_cnt increments; sel and gnt hold.
- GRANT, release:
  - ptr <= (sel+1) mod 8, with wrap from 7 to 0.
  - If en=1 and (req with bit sel masked)!=0, the winner is chosen from the masked vector starting at (sel+1) mod 8. It is granted on the next edge (back-to-back handover): sel and gnt change, busy stays 1, hold_cnt=1.
  - Otherwise go to IDLE: gnt=0, busy=0, sel holds its last value.
  - Masking the released holder guarantees handover to a different requester. A sole requester that hits MAX_HOLD sees one IDLE cycle and is then re-granted.
- en=0 in GRANT: release on that edge and go to IDLE; no new grant until en=1.
- Data path: at each edge, y <= (state==GRANT) ? din[sel] : 0, using the pre-edge sel. y therefore lags gnt by one cycle.
- gnt is always 0 or exactly one-hot, and gnt[sel]==busy in every cycle.
- Invariant: after a grant to k, each other continuously requesting index is granted before k again. Worst-case wait is 7*MAX_HOLD + 7 cycles.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then req=0, en=1 -> sel=0, gnt=0, busy=0, y=0 held; ptr=0.
- Single request with data path:
  - Stimulus: req=8'b0000_0100, din=8'b0000_0100, en=1 for 3 cycles, then req=0.
  - Response: gnt=8'b0000_0100, sel=2 one cycle after req; y=1 one cycle later.
  - After req drops: IDLE with gnt=0, and y=0 the following cycle.
- Round-robin rotation with hold limit:
  - Stimulus: req=8'hFF held, MAX_HOLD=4.
  - Response: grants in order 0,1,...,7,0, each exactly 4 cycles, back-to-back with busy never dropping; sel wraps 7->0.
- Fairness after wrap:
  - Stimulus: ptr=6 (after granting 5); req=8'b1000_0011.
  - Response: grant 7, then 0, then 1.
- Sole requester expiry and enable:
  - Stimulus: req=8'b0000_1000 held.
  - Response: gnt=8'h08 for 4 cycles, gnt=0 for 1 cycle, gnt=8'h08 again.
  - Dropping en mid-grant -> gnt=0 on the next edge; no grant while en=0.
- Reset mid-operation:
  - Stimulus: rst=1 while sel=5 is granted.
  - Response: gnt=0, sel=0, y=0 on the next edge.
  - With req=8'hFF, the first grant after rst falls is index 0.
